video_test_source: RTL

- Synthesizable video timing and test-pattern transmitter, clocked from the 12 MHz system clock.
- Drives the same video interface the game core presents to the display and scan-converter path:
  - 9-bit BGR333 pixel;
  - active-low hsync, vsync and composite sync;
  - active-high hblank and vblank;
  - 6 MHz pixel enable.
- Used to bring up and verify the display side (SDL sim display, scan doubler, FPGA video out) independently of the game core.

---
 rtl/vidgen_pkg.sv | 32 +++
 rtl/vidgen_pattern.sv | 48 ++++
 rtl/video_test_source.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/vidgen_pkg.sv
// Shared timing defaults, pattern mode encoding and pixel packing for the
// video test source.
package vidgen_pkg;

    localparam int H_TOTAL_D      = 384;
    localparam int H_ACTIVE_D     = 256;
    localparam int H_SYNC_START_D = 280;
    localparam int H_SYNC_LEN_D   = 32;
    localparam int V_TOTAL_D      = 262;
    localparam int V_ACTIVE_D     = 240;
    localparam int V_SYNC_START_D = 244;
    localparam int V_SYNC_LEN_D   = 4;

    localparam logic [8:0] RGB_BLACK = 9'h000;
    localparam logic [8:0] RGB_WHITE = 9'h1FF;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_GRID  = 2'd1,
        MODE_SOLID = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_t;

    function automatic logic [8:0] bgr333(
        input logic [2:0] b,
        input logic [2:0] g,
        input logic [2:0] r
    );
        return {b, g, r};
    endfunction

endpackage

// File: rtl/vidgen_pattern.sv
// Combinational test-pattern generator: (h, v, frame, mode, solid) -> BGR333.
// With VIDGEN_SCROLL_EN defined, bars and grid scroll by the frame counter.
module vidgen_pattern
    import vidgen_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int V_ACTIVE = V_ACTIVE_D
) (
    input  logic [8:0] h,
    input  logic [8:0] v,
    input  logic [7:0] frame,
    input  mode_t      mode,
    input  logic [8:0] solid,
    output logic [8:0] rgb
);

    logic [7:0] hx;
    logic [2:0] bar;
    logic       grid_on;

`ifdef VIDGEN_SCROLL_EN
    assign hx = h[7:0] + frame;
`else
    logic frame_unused;
    assign frame_unused = ^frame[7:3];
    assign hx = h[7:0];
`endif

    assign bar = hx[7:5];

    // The last visible column/row are always lit so the frame edge is visible.
    assign grid_on = (hx[3:0] == 4'd0)
                  || (v[3:0] == 4'd0)
                  || (h == 9'(H_ACTIVE - 1))
                  || (v == 9'(V_ACTIVE - 1));

    always_comb begin
        rgb = RGB_BLACK;
        unique case (mode)
            MODE_BARS:  rgb = bgr333({3{bar[2]}}, {3{bar[1]}}, {3{bar[0]}});
            MODE_GRID:  rgb = grid_on ? RGB_WHITE : RGB_BLACK;
            MODE_SOLID: rgb = solid;
            MODE_GRAD:  rgb = bgr333(frame[2:0], v[7:5], h[7:5]);
            default:    rgb = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/video_test_source.sv
// Video timing and test-pattern transmitter (counters, syncs, output regs).
// Optional VIDGEN_SCROLL_EN makes bars/grid scroll one pixel per frame.
module video_test_source
    import vidgen_pkg::*;
#(
    parameter int H_TOTAL      = H_TOTAL_D,
    parameter int H_ACTIVE     = H_ACTIVE_D,
    parameter int H_SYNC_START = H_SYNC_START_D,
    parameter int H_SYNC_LEN   = H_SYNC_LEN_D,
    parameter int V_TOTAL      = V_TOTAL_D,
    parameter int V_ACTIVE     = V_ACTIVE_D,
    parameter int V_SYNC_START = V_SYNC_START_D,
    parameter int V_SYNC_LEN   = V_SYNC_LEN_D
) (
    input  logic       clk_12mhz,
    input  logic       reset_n,
    input  logic       enable_i,
    input  logic [1:0] mode_i,
    input  logic [8:0] solid_i,
    output logic [8:0] rgb_o,
    output logic       sync_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       hblank_o,
    output logic       vblank_o,
    output logic       clk_6mhz_o,
    output logic [8:0] hcount_o,
    output logic [8:0] vcount_o,
    output logic [7:0] frame_o
);

    if (H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_hsync_check
        $error("hsync window runs past H_TOTAL");
    end
    if (V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_vsync_check
        $error("vsync window runs past V_TOTAL");
    end

    localparam logic [9:0] HS_LO = 10'(H_SYNC_START);
    localparam logic [9:0] HS_HI = 10'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [9:0] VS_LO = 10'(V_SYNC_START);
    localparam logic [9:0] VS_HI = 10'(V_SYNC_START + V_SYNC_LEN);

    logic       en_q;
    logic       pe;
    logic       step;
    logic [8:0] h;
    logic [8:0] v;
    logic       h_last;
    logic       v_last;
    logic       at_origin;
    mode_t      mode_q;
    mode_t      mode_sel;
    logic [8:0] solid_q;
    logic [8:0] solid_sel;
    logic [8:0] pat_rgb;
    logic       hb;
    logic       vb;
    logic       hs_n;
    logic       vs_n;

    assign step      = pe & enable_i;
    assign h_last    = (h == 9'(H_TOTAL - 1));
    assign v_last    = (v == 9'(V_TOTAL - 1));
    assign at_origin = (h == 9'd0) && (v == 9'd0);

    // The origin pixel already uses the newly sampled mode/solid.
    assign mode_sel  = at_origin ? mode_t'(mode_i) : mode_q;
    assign solid_sel = at_origin ? solid_i : solid_q;

    assign hb   = ({1'b0, h} >= 10'(H_ACTIVE));
    assign vb   = ({1'b0, v} >= 10'(V_ACTIVE));
    assign hs_n = !(({1'b0, h} >= HS_LO) && ({1'b0, h} < HS_HI));
    assign vs_n = !(({1'b0, v} >= VS_LO) && ({1'b0, v} < VS_HI));

    assign clk_6mhz_o = pe;

    vidgen_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pattern (
        .h     (h),
        .v     (v),
        .frame (frame_o),
        .mode  (mode_sel),
        .solid (solid_sel),
        .rgb   (pat_rgb)
    );

    // Registered enable delays the first pixel-enable by one extra clk.
    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            en_q <= 1'b0;
            pe   <= 1'b0;
        end else begin
            en_q <= enable_i;
            pe   <= enable_i & en_q & ~pe;
        end
    end

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            h <= 9'd0;
            v <= 9'd0;
        end else if (!enable_i) begin
            h <= 9'd0;
            v <= 9'd0;
        end else if (step) begin
            h <= h_last ? 9'd0 : h + 9'd1;
            if (h_last) begin
                v <= v_last ? 9'd0 : v + 9'd1;
            end
        end
    end

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            frame_o <= 8'd0;
        end else if (step && h_last && v_last) begin
            frame_o <= frame_o + 8'd1;
        end
    end

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= MODE_BARS;
            solid_q <= 9'd0;
        end else if (step && at_origin) begin
            mode_q  <= mode_sel;
            solid_q <= solid_sel;
        end
    end

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            rgb_o    <= RGB_BLACK;
            sync_o   <= 1'b1;
            hsync_o  <= 1'b1;
            vsync_o  <= 1'b1;
            hblank_o <= 1'b1;
            vblank_o <= 1'b1;
            hcount_o <= 9'd0;
            vcount_o <= 9'd0;
        end else if (step) begin
            rgb_o    <= (hb | vb) ? RGB_BLACK : pat_rgb;
            sync_o   <= hs_n & vs_n;
            hsync_o  <= hs_n;
            vsync_o  <= vs_n;
            hblank_o <= hb;
            vblank_o <= vb;
            hcount_o <= h;
            vcount_o <= v;
        end
    end

endmodule
